// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial two's-complement adder. One full-adder cell and one carry flop
// process one bit per clock, LSB first. An accepted start captures the
// operands, WIDTH RUN cycles produce the result, and a one-cycle DONE state
// presents it.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     request pulse, only looked at in IDLE
//   a, b      signed operands, captured on an accepted start
//   cin       carry-in, captured on an accepted start (cin=1, b=~x gives a-x)
//   busy      high while the operation is running
//   done      one-cycle pulse; sum/cout/overflow are valid in this cycle
//   sum       a+b+cin modulo 2^WIDTH (registered, holds until next done)
//   cout      unsigned carry out of bit WIDTH-1
//   overflow  signed overflow (carry into MSB xor carry out of MSB)
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    // Bit counter only needs to reach WIDTH-1.
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_reg,   state_next;
    logic [WIDTH-1:0] shift_a_reg, shift_a_next;
    logic [WIDTH-1:0] shift_b_reg, shift_b_next;
    logic [WIDTH-1:0] res_reg,     res_next;
    logic             carry_reg,   carry_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic [WIDTH-1:0] sum_reg,     sum_next;
    logic             cout_reg,    cout_next;
    logic             ovf_reg,     ovf_next;

    // Single full-adder cell working on the current LSBs.
    logic fa_s;
    logic fa_c;

    assign fa_s = shift_a_reg[0] ^ shift_b_reg[0] ^ carry_reg;
    assign fa_c = (shift_a_reg[0] & shift_b_reg[0]) |
                  (shift_a_reg[0] & carry_reg)      |
                  (shift_b_reg[0] & carry_reg);

    // Right-shifted views of the operand and result registers. The operands
    // shift in zeros; the result shifts the new sum bit in at the MSB so that
    // after WIDTH steps the first (LSB) bit has landed in bit 0.
    logic [WIDTH-1:0] shift_a_sh;
    logic [WIDTH-1:0] shift_b_sh;
    logic [WIDTH-1:0] res_sh;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign shift_a_sh[gi] = shift_a_reg[gi+1];
            assign shift_b_sh[gi] = shift_b_reg[gi+1];
            assign res_sh[gi]     = res_reg[gi+1];
        end
    endgenerate

    assign shift_a_sh[WIDTH-1] = 1'b0;
    assign shift_b_sh[WIDTH-1] = 1'b0;
    assign res_sh[WIDTH-1]     = fa_s;

    // -------------------------------------------------------------------------
    // Next-state and datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        shift_a_next = shift_a_reg;
        shift_b_next = shift_b_reg;
        res_next     = res_reg;
        carry_next   = carry_reg;
        cnt_next     = cnt_reg;
        sum_next     = sum_reg;
        cout_next    = cout_reg;
        ovf_next     = ovf_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    shift_a_next = a;
                    shift_b_next = b;
                    carry_next   = cin;
                    res_next     = '0;
                    cnt_next     = '0;
                    state_next   = S_RUN;
                end
            end

            S_RUN: begin
                shift_a_next = shift_a_sh;
                shift_b_next = shift_b_sh;
                res_next     = res_sh;
                carry_next   = fa_c;
                cnt_next     = cnt_reg + CNT_W'(1);
                if (cnt_reg == LAST_BIT) begin
                    // On the MSB step carry_reg is the carry into the MSB and
                    // fa_c the carry out of it, so overflow is their xor.
                    sum_next   = res_sh;
                    cout_next  = fa_c;
                    ovf_next   = carry_reg ^ fa_c;
                    cnt_next   = '0;
                    state_next = S_DONE;
                end
            end

            S_DONE: begin
                // start is deliberately not looked at here.
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            shift_a_reg <= '0;
            shift_b_reg <= '0;
            res_reg     <= '0;
            carry_reg   <= 1'b0;
            cnt_reg     <= '0;
            sum_reg     <= '0;
            cout_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_a_reg <= shift_a_next;
            shift_b_reg <= shift_b_next;
            res_reg     <= res_next;
            carry_reg   <= carry_next;
            cnt_reg     <= cnt_next;
            sum_reg     <= sum_next;
            cout_reg    <= cout_next;
            ovf_reg     <= ovf_next;
        end
    end

    // Status decodes straight from the state register, so busy and done are
    // mutually exclusive by construction.
    assign busy     = (state_reg == S_RUN);
    assign done     = (state_reg == S_DONE);
    assign sum      = sum_reg;
    assign cout     = cout_reg;
    assign overflow = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Directed self-checking bench for serial_adder at WIDTH=8. Inputs are driven
// on the falling edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    int n_cmp;
    int n_bad;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    task automatic test_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;     // reset must win over start
        a     = 8'd55;
        b     = 8'd66;
        cin   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++; $display("FAIL reset_done: got %b expected 0", done);
        end
        n_cmp++;
        if ({sum, cout, overflow} !== 10'd0) begin
            n_bad++; $display("FAIL reset_outputs: got sum=%h cout=%b ovf=%b expected 0/0/0",
                              sum, cout, overflow);
        end
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle_after: got busy=%b expected 0", busy);
        end
        $display("reset: busy=%b done=%b sum=%h", busy, done, sum);
    endtask

    // -------------------------------------------------------------------------
    // One full operation: single-cycle start, operands scrambled after capture,
    // busy counted, done and results checked, then done drop and hold checked.
    task automatic test_add(input string name, input logic [7:0] ta, input logic [7:0] tb,
                            input logic tc, input logic [7:0] exp_sum,
                            input logic exp_cout, input logic exp_ovf);
        int busy_cnt;
        int guard;
        @(negedge clk);
        a     = ta;
        b     = tb;
        cin   = tc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = ~ta;
        b     = 8'h5A;
        cin   = ~tc;
        busy_cnt = 0;
        guard    = 0;
        while (busy === 1'b1 && guard < 40) begin
            if (done !== 1'b0) begin
                n_cmp++; n_bad++;
                $display("FAIL %s_busy_done_overlap: got done=%b expected 0", name, done);
            end
            busy_cnt++;
            guard++;
            @(negedge clk);
        end
        n_cmp++;
        if (busy_cnt != WIDTH) begin
            n_bad++; $display("FAIL %s_busy_cycles: got %0d expected %0d", name, busy_cnt, WIDTH);
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++; $display("FAIL %s_done: got %b expected 1", name, done);
        end
        n_cmp++;
        if (sum !== exp_sum) begin
            n_bad++; $display("FAIL %s_sum: got %h expected %h", name, sum, exp_sum);
        end
        n_cmp++;
        if (cout !== exp_cout) begin
            n_bad++; $display("FAIL %s_cout: got %b expected %b", name, cout, exp_cout);
        end
        n_cmp++;
        if (overflow !== exp_ovf) begin
            n_bad++; $display("FAIL %s_overflow: got %b expected %b", name, overflow, exp_ovf);
        end
        $display("%s: a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b busy_cycles=%0d",
                 name, ta, tb, tc, sum, cout, overflow, busy_cnt);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL %s_done_pulse: got done=%b busy=%b expected 0/0", name, done, busy);
        end
        n_cmp++;
        if (sum !== exp_sum || cout !== exp_cout || overflow !== exp_ovf) begin
            n_bad++; $display("FAIL %s_hold: got %h/%b/%b expected %h/%b/%b",
                              name, sum, cout, overflow, exp_sum, exp_cout, exp_ovf);
        end
    endtask

    // -------------------------------------------------------------------------
    // start re-pulsed with other operands mid-RUN must be ignored.
    task automatic test_restart_ignored();
        int done_cnt;
        @(negedge clk);
        a = 8'd1; b = 8'd1; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 8'd9; b = 8'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            if (done === 1'b1) begin
                done_cnt++;
                n_cmp++;
                if (sum !== 8'd2) begin
                    n_bad++; $display("FAIL restart_sum: got %h expected 02", sum);
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_bad++; $display("FAIL restart_done_count: got %0d expected 1", done_cnt);
        end
        $display("restart_ignored: done_pulses=%0d sum=%h", done_cnt, sum);
    endtask

    // -------------------------------------------------------------------------
    // start held high: ignored on the DONE->IDLE edge, accepted one edge later.
    task automatic test_back_to_back();
        int guard;
        @(negedge clk);
        a = 8'd10; b = 8'd20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        guard = 0;
        while (done !== 1'b1 && guard < 40) begin
            guard++;
            @(negedge clk);
        end
        n_cmp++;
        if (done !== 1'b1 || sum !== 8'd30) begin
            n_bad++; $display("FAIL b2b_first: got done=%b sum=%h expected 1/1e", done, sum);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL b2b_idle_gap: got busy=%b done=%b expected 0/0", busy, done);
        end
        a = 8'd100; b = 8'd50;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL b2b_second_accept: got busy=%b expected 1", busy);
        end
        start = 1'b0;
        guard = 0;
        while (done !== 1'b1 && guard < 40) begin
            guard++;
            @(negedge clk);
        end
        n_cmp++;
        if (done !== 1'b1 || sum !== 8'd150 || overflow !== 1'b1 || cout !== 1'b0) begin
            n_bad++; $display("FAIL b2b_second: got done=%b sum=%h cout=%b ovf=%b expected 1/96/0/1",
                              done, sum, cout, overflow);
        end
        $display("back_to_back: second sum=%h cout=%b ovf=%b", sum, cout, overflow);
        @(negedge clk);
    endtask

    // -------------------------------------------------------------------------
    // Reset on the 4th RUN cycle aborts with no done, then a fresh op works.
    task automatic test_reset_mid_run();
        int done_cnt;
        @(negedge clk);
        a = 8'd100; b = 8'd27; cin = 1'b0; start = 1'b1;
        @(negedge clk);               // RUN cycle 1
        start = 1'b0;
        @(negedge clk);               // RUN cycle 2
        @(negedge clk);               // RUN cycle 3
        @(negedge clk);               // RUN cycle 4
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL abort_status: got busy=%b done=%b expected 0/0", busy, done);
        end
        n_cmp++;
        if ({sum, cout, overflow} !== 10'd0) begin
            n_bad++; $display("FAIL abort_outputs: got sum=%h cout=%b ovf=%b expected 0/0/0",
                              sum, cout, overflow);
        end
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (done_cnt != 0) begin
            n_bad++; $display("FAIL abort_no_done: got %0d active cycles expected 0", done_cnt);
        end
        $display("reset_mid_run: busy=%b done=%b sum=%h", busy, done, sum);
        test_add("after_abort", 8'd2, 8'd2, 1'b0, 8'd4, 1'b0, 1'b0);
    endtask

    // -------------------------------------------------------------------------
    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;

        test_reset();
        test_add("add_3_4",      8'd3,   8'd4,   1'b0, 8'h07, 1'b0, 1'b0);
        test_add("add_127_1",    8'h7F,  8'h01,  1'b0, 8'h80, 1'b0, 1'b1);
        test_add("add_m1_m1",    8'hFF,  8'hFF,  1'b0, 8'hFE, 1'b1, 1'b0);
        test_add("add_m128_m1",  8'h80,  8'hFF,  1'b0, 8'h7F, 1'b1, 1'b1);
        test_add("sub_5_3",      8'h05,  8'hFC,  1'b1, 8'h02, 1'b1, 1'b0);
        test_add("cin_7f_0",     8'h7F,  8'h00,  1'b1, 8'h80, 1'b0, 1'b1);
        test_add("add_m3_m4",    8'hFD,  8'hFC,  1'b0, 8'hF9, 1'b1, 1'b0);
        test_restart_ignored();
        test_back_to_back();
        test_reset_mid_run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
